// File: rtl/mxv_result_collector.sv
// Collects packed result words from the matrix-by-vector engine, masks padding
// slots of the final word, buffers them in a show-ahead FIFO and flags completion.
module mxv_result_collector #(
   parameter int element_width = 32,
   parameter int NI            = 8,
   parameter int DEPTH         = 4,
   parameter int ADDR_W        = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [31:0]                 total_rows,
   input  logic                        in_valid,
   input  logic [NI*element_width-1:0] in_data,
   output logic [NI*element_width-1:0] out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        finish,
   output logic                        overflow
);

   localparam int WORD_W = NI * element_width;
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [31:0]         words_expected_q, words_expected_d;
   logic [31:0]         rows_latched_q, rows_latched_d;
   logic [31:0]         words_in_q, words_in_d;
   logic [31:0]         words_out_q, words_out_d;
   logic                finish_q, finish_d;
   logic                overflow_q, overflow_d;
   logic [WORD_W-1:0]   mem_q [DEPTH];
   logic [WORD_W-1:0]   mem_d [DEPTH];
   logic                push, pop;
   logic [32:0]         rows_round_up;

   // Slot k of word idx survives only while its global element index is below rows.
   function automatic logic [WORD_W-1:0] mask_word(input logic [WORD_W-1:0] w,
                                                   input logic [31:0] idx,
                                                   input logic [31:0] rows);
      logic [WORD_W-1:0] r;
      logic [63:0]       pos;
      r = w;
      for (int k = 0; k < NI; k++) begin
         pos = 64'(idx) * 64'(NI) + 64'(k);
         if (pos >= 64'(rows))
            r[(NI-k)*element_width-1 -: element_width] = '0;
      end
      return r;
   endfunction

   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_last  = out_valid && (words_out_q == words_expected_q - 32'd1);
   assign finish    = finish_q;
   assign overflow  = overflow_q;
   assign pop       = out_valid && out_ready;
   assign rows_round_up = {1'b0, total_rows} + 33'(NI - 1);

   always_comb begin
      state_d          = state_q;
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      count_d          = count_q;
      words_expected_d = words_expected_q;
      rows_latched_d   = rows_latched_q;
      words_in_d       = words_in_q;
      words_out_d      = words_out_q;
      finish_d         = finish_q;
      overflow_d       = overflow_q;
      mem_d            = mem_q;
      push             = 1'b0;

      if (!start) begin
         state_d          = IDLE;
         wr_ptr_d         = '0;
         rd_ptr_d         = '0;
         count_d          = '0;
         words_expected_d = '0;
         words_in_d       = '0;
         words_out_d      = '0;
         finish_d         = 1'b0;
         overflow_d       = 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            words_out_d = words_out_q + 32'd1;
         end
         case (state_q)
            IDLE: begin
               words_expected_d = 32'(rows_round_up / 33'(NI));
               rows_latched_d   = total_rows;
               state_d          = (total_rows == 32'd0) ? DONE : COLLECT;
            end
            COLLECT: begin
               if (in_valid) begin
                  if (count_q != FULL_CNT || pop) begin
                     push       = 1'b1;
                     words_in_d = words_in_q + 32'd1;
                     if (words_in_q + 32'd1 == words_expected_q)
                        state_d = DRAIN;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end
            DRAIN: ;
            DONE:  finish_d = 1'b1;
            default: state_d = IDLE;
         endcase

         if (push) begin
            mem_d[wr_ptr_q] = mask_word(in_data, words_in_q, rows_latched_q);
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (push && !pop)
            count_d = count_q + CNT_ONE;
         else if (pop && !push)
            count_d = count_q - CNT_ONE;

         // The final pop and the move to DONE share an edge.
         if (state_q == DRAIN && count_d == '0)
            state_d = DONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         words_expected_q <= '0;
         rows_latched_q   <= '0;
         words_in_q       <= '0;
         words_out_q      <= '0;
         finish_q         <= 1'b0;
         overflow_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         words_expected_q <= words_expected_d;
         rows_latched_q   <= rows_latched_d;
         words_in_q       <= words_in_d;
         words_out_q      <= words_out_d;
         finish_q         <= finish_d;
         overflow_q       <= overflow_d;
      end
   end

   // Storage is gated by count on the output, so it needs no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_mxv_result_collector.sv
// Directed bench for mxv_result_collector: latency, masking, overflow, flush and reset.
module tb_mxv_result_collector;

   localparam int W = 256;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [31:0]  total_rows;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         finish;
   logic         overflow;

   int checks   = 0;
   int failures = 0;

   localparam logic [W-1:0] ALL_F  = {8{32'hFFFF_FFFF}};
   localparam logic [W-1:0] M13    = {{5{32'hFFFF_FFFF}}, {3{32'h0}}};
   localparam logic [W-1:0] M20    = {{4{32'hFFFF_FFFF}}, {4{32'h0}}};
   localparam logic [W-1:0] WA     = {8{32'h1111_2222}};
   localparam logic [W-1:0] WB     = {8{32'h3333_4444}};
   localparam logic [W-1:0] WD     = {8{32'hDDDD_0001}};

   mxv_result_collector dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .total_rows (total_rows),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .finish     (finish),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pat(input int i);
      return {8{32'hA000_0000 + 32'(i)}};
   endfunction

   initial begin
      reset = 1'b1; start = 1'b0; total_rows = '0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check_val("rst_out_valid", W'(out_valid), W'(0));
      check_val("rst_out_data", out_data, '0);
      check_val("rst_finish", W'(finish), W'(0));
      check_val("rst_overflow", W'(overflow), W'(0));
      check_val("rst_out_last", W'(out_last), W'(0));

      // 16 rows, two words, consumer always ready
      total_rows = 32'd16; start = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b1; in_data = WA;
      tick();
      check_val("t1_valid_w0", W'(out_valid), W'(1));
      check_val("t1_data_w0", out_data, WA);
      check_val("t1_last_w0", W'(out_last), W'(0));
      in_data = WB;
      tick();
      check_val("t1_valid_w1", W'(out_valid), W'(1));
      check_val("t1_data_w1", out_data, WB);
      check_val("t1_last_w1", W'(out_last), W'(1));
      check_val("t1_finish_early", W'(finish), W'(0));
      in_valid = 1'b0;
      tick();
      check_val("t1_empty", W'(out_valid), W'(0));
      check_val("t1_finish_pop_edge", W'(finish), W'(0));
      tick();
      check_val("t1_finish", W'(finish), W'(1));
      tick();
      check_val("t1_finish_held", W'(finish), W'(1));

      // 13 rows: final word keeps slots 0-4 only
      start = 1'b0; tick();
      check_val("t2_flush_finish", W'(finish), W'(0));
      total_rows = 32'd13; start = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b1; in_data = ALL_F;
      tick(); tick();
      in_valid = 1'b0;
      check_val("t2_word0", out_data, ALL_F);
      check_val("t2_last0", W'(out_last), W'(0));
      out_ready = 1'b1;
      tick();
      check_val("t2_word1_masked", out_data, M13);
      check_val("t2_last1", W'(out_last), W'(1));
      tick(); tick();
      check_val("t2_finish", W'(finish), W'(1));

      // 40 rows, stalled consumer: fifth word dropped, then push+pop at full
      start = 1'b0; tick();
      total_rows = 32'd40; start = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = pat(i);
         tick();
      end
      check_val("t3_overflow", W'(overflow), W'(1));
      check_val("t3_head", out_data, pat(0));
      out_ready = 1'b1; in_data = WD;
      tick();
      in_valid = 1'b0;
      check_val("t3_head_after_pp", out_data, pat(1));
      tick();
      check_val("t3_head2", out_data, pat(2));
      tick();
      check_val("t3_head3", out_data, pat(3));
      check_val("t3_last3", W'(out_last), W'(0));
      tick();
      check_val("t3_headD", out_data, WD);
      check_val("t3_lastD", W'(out_last), W'(1));
      tick();
      check_val("t3_empty", W'(out_valid), W'(0));
      check_val("t3_overflow_sticky", W'(overflow), W'(1));
      tick();
      check_val("t3_finish", W'(finish), W'(1));

      // zero rows: finish two edges after start, nothing emitted
      start = 1'b0; tick();
      check_val("t4_ovf_cleared", W'(overflow), W'(0));
      total_rows = 32'd0; start = 1'b1; in_valid = 1'b1; in_data = WA;
      tick();
      check_val("t4_finish_edge1", W'(finish), W'(0));
      check_val("t4_valid_edge1", W'(out_valid), W'(0));
      tick();
      check_val("t4_finish_edge2", W'(finish), W'(1));
      check_val("t4_valid_edge2", W'(out_valid), W'(0));
      in_valid = 1'b0;

      // start dropped mid-collect, then fresh 20-row collection
      start = 1'b0; tick();
      total_rows = 32'd20; start = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b1; in_data = ALL_F;
      tick();
      in_valid = 1'b0;
      check_val("t5_valid_before_abort", W'(out_valid), W'(1));
      start = 1'b0;
      tick();
      check_val("t5_abort_valid", W'(out_valid), W'(0));
      check_val("t5_abort_finish", W'(finish), W'(0));
      start = 1'b1;
      tick();
      in_valid = 1'b1;
      tick(); tick(); tick();
      in_valid = 1'b0;
      check_val("t5_w0", out_data, ALL_F);
      out_ready = 1'b1;
      tick();
      check_val("t5_w1", out_data, ALL_F);
      tick();
      check_val("t5_w2_masked", out_data, M20);
      check_val("t5_w2_last", W'(out_last), W'(1));
      tick(); tick();
      check_val("t5_finish", W'(finish), W'(1));

      // async reset between edges while draining with overflow set
      start = 1'b0; tick();
      total_rows = 32'd40; start = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = pat(i);
         tick();
      end
      out_ready = 1'b1; in_data = WD;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check_val("t6_pre_valid", W'(out_valid), W'(1));
      check_val("t6_pre_overflow", W'(overflow), W'(1));
      #2 reset = 1'b1;
      #1;
      check_val("t6_rst_valid", W'(out_valid), W'(0));
      check_val("t6_rst_finish", W'(finish), W'(0));
      check_val("t6_rst_overflow", W'(overflow), W'(0));
      check_val("t6_rst_data", out_data, '0);
      check_val("t6_rst_last", W'(out_last), W'(0));
      tick();
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mxv_result_collector.md
Name: mxv_result_collector

Overview:
- Sits directly downstream of the matrix-by-vector engine.
- Captures each NI-element packed result word from the engine's decoder when `outsider_read_now` pulses.
- Zeroes padding slots in the final partial word, buffers words in a small show-ahead FIFO, and hands them downstream over valid/ready.
- Asserts `finish` once every expected result element has been delivered, so the solver control can start the next vector operation.

Parameters:
- element_width, 32, bits per result element.
- NI, 8, elements per packed word; must match the engine's NI.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk, input, 1, sole clock; all logic on rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- start, input, 1, level enable; low returns the block to IDLE.
- total_rows, input, 32, number of valid result elements; sampled on IDLE→active.
- in_valid, input, 1, word strobe from the engine (`outsider_read_now`).
- in_data, input, NI*element_width, packed result word; element 0 in the MSB slice.
- out_data, output, NI*element_width, FIFO head word.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, downstream accept.
- out_last, output, 1, head is the final word of the vector.
- finish, output, 1, all words delivered.
- overflow, output, 1, sticky: a word was dropped on a full FIFO.

Behaviour:
- **Reset (async, high):**
  - state=IDLE; FIFO pointers and count=0; words_expected, words_in, words_out=0.
  - finish=0, overflow=0, out_valid=0, out_last=0, out_data=0.
- **States:** IDLE, COLLECT, DRAIN, DONE.
- **start low (any state, synchronous):**
  - Next edge: state=IDLE, FIFO flushed, counters cleared, finish=0, overflow=0.
  - in_valid in that cycle is ignored.
- **IDLE with start=1:**
  - Latch words_expected = ceil(total_rows/NI), computed as (total_rows+NI-1)/NI in 33-bit arithmetic.
  - Latch rows_latched = total_rows.
  - If total_rows==0 → DONE; else → COLLECT.
  - in_valid in this cycle is ignored.
- **COLLECT, push condition:** in_valid=1 and (count<DEPTH or a pop occurs the same cycle).
- **COLLECT, push action:**
  - Write the masked word; words_in += 1.
  - Slot k (0..NI-1, MSB-first) of word w is kept iff w*NI+k < rows_latched; otherwise forced to 32'd0.
- **COLLECT, full FIFO:** in_valid with count==DEPTH and no pop → word dropped, overflow←1 (sticky), words_in unchanged.
- **COLLECT → DRAIN:** on the edge where words_in reaches words_expected.
- **DRAIN:** in_valid ignored and not flagged as overflow. → DONE when count==0, including the edge of the last pop.
- **DONE:** finish=1, held until start goes low. in_valid ignored.
- **FIFO:**
  - Show-ahead: out_data/out_valid reflect the head.
  - Pop = out_valid & out_ready.
  - Latency: a push at edge N makes out_valid=1 after edge N when the FIFO was empty.
  - Simultaneous push and pop: count unchanged; both pointers wrap modulo DEPTH.
- **out_last:** 1 iff out_valid and head word index == words_expected-1. Tracked via words_out; words_out increments on pop.
- **finish timing:** asserts the edge after the final pop. For total_rows==0, the edge after DONE entry.
- **Reset mid-operation:** outputs drop immediately, asynchronously, to their reset values.

Test Plan:
- total_rows=16, out_ready=1, two in_valid words → each out_valid one cycle after its push; out_last with word 2; finish=1 one cycle after the second pop.
- total_rows=13, two words of all 0xFFFFFFFF → second output word has slots 0-4 = 0xFFFFFFFF and slots 5-7 = 0; first word unmasked.
- total_rows=40, out_ready=0, five consecutive in_valid → FIFO holds 4 words, 5th dropped, overflow=1. Then with count=4, assert out_ready and in_valid together → push accepted, count stays 4.
- total_rows=0, start raised → finish=1 two edges after start; out_valid never asserts.
- start dropped mid-COLLECT after 1 of 3 words → next edge: out_valid=0, finish=0. Re-raise start → fresh collection with correct masking.
- Async reset asserted mid-DRAIN between clock edges → out_valid, finish and overflow read 0 before the next clk edge.
